// File: rtl/pfb_mul_pkg.sv
// Shared constants and width helpers for the PFB decimator multiplier and its scaler.
package pfb_mul_pkg;

    localparam int NUM_STAGE_MIN  = 1;
    localparam int NUM_STAGE_MAX  = 6;
    localparam int SHIFT_MIN      = 0;
    localparam int MAX_DOUT_WIDTH = 62;

    // Exact signed product of two one-bit-extended operands.
    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 1;
    endfunction

    function automatic int shift_max(input int w0, input int w1);
        return w0 + w1 - 1;
    endfunction

    // Width left after rounding headroom is added and SHIFT bits are dropped.
    function automatic int scaled_width(input int w0, input int w1, input int shift);
        return w0 + w1 + 2 - shift;
    endfunction

    function automatic longint sat_hi(input int dout_w, input bit is_signed);
        return is_signed ? ((longint'(1) <<< (dout_w - 1)) - 1) : ((longint'(1) <<< dout_w) - 1);
    endfunction

    function automatic longint sat_lo(input int dout_w, input bit is_signed);
        return is_signed ? -(longint'(1) <<< (dout_w - 1)) : longint'(0);
    endfunction

endpackage

// File: rtl/pfb_block_decimator_mul_pipe_if.sv
// Operand/result stream bundle for the PFB multiplier pipeline.
interface pfb_block_decimator_mul_pipe_if #(
    parameter int DIN0_WIDTH = 11,
    parameter int DIN1_WIDTH = 13,
    parameter int DOUT_WIDTH = 23,
    parameter int USER_WIDTH = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic [USER_WIDTH-1:0] in_user;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic [USER_WIDTH-1:0] out_user;
    logic                  out_sat;

    modport master (
        output in_valid, din0, din1, in_user, out_ready,
        input  in_ready, out_valid, dout, out_user, out_sat
    );

    modport slave (
        input  in_valid, din0, din1, in_user, out_ready,
        output in_ready, out_valid, dout, out_user, out_sat
    );
endinterface

// File: rtl/pfb_mul_scale.sv
// Combinational round-half-up, arithmetic right shift and optional clamp of a signed product.
module pfb_mul_scale
    import pfb_mul_pkg::*;
#(
    parameter int PROD_WIDTH = 25,
    parameter int DOUT_WIDTH = 23,
    parameter int OUT_SIGNED = 0,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int SATURATE   = 0
) (
    input  logic signed [PROD_WIDTH-1:0] prod,
    output logic        [DOUT_WIDTH-1:0] dout,
    output logic                         sat
);

    localparam int RW      = PROD_WIDTH + 1;
    localparam int CW      = (RW > DOUT_WIDTH + 1) ? RW : DOUT_WIDTH + 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [RW-1:0] RND_ADD =
        (ROUND != 0 && SHIFT > 0) ? (RW'(1) << RND_POS) : RW'(0);
    localparam logic signed [CW-1:0] HI = CW'(sat_hi(DOUT_WIDTH, OUT_SIGNED != 0));
    localparam logic signed [CW-1:0] LO = CW'(sat_lo(DOUT_WIDTH, OUT_SIGNED != 0));

    logic signed [RW-1:0] rounded;
    logic signed [RW-1:0] shifted;
    logic signed [CW-1:0] wide;
    logic                 over;
    logic                 under;

    // The comparison width covers both the scaled value and the output bounds.
    always_comb begin
        rounded = RW'(prod) + RND_ADD;
        shifted = rounded >>> SHIFT;
        wide    = CW'(shifted);
        over    = wide > HI;
        under   = wide < LO;
        dout    = wide[DOUT_WIDTH-1:0];
        sat     = 1'b0;
        if (SATURATE != 0) begin
            if (over) begin
                dout = HI[DOUT_WIDTH-1:0];
                sat  = 1'b1;
            end else if (under) begin
                dout = LO[DOUT_WIDTH-1:0];
                sat  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pfb_block_decimator_mul_pipe.sv
// Flow-controlled multiply pipeline: operand register, product stages, scaled result register.
module pfb_block_decimator_mul_pipe
    import pfb_mul_pkg::*;
#(
    parameter int DIN0_WIDTH  = 11,
    parameter int DIN1_WIDTH  = 13,
    parameter int DOUT_WIDTH  = 23,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 3,
    parameter int SHIFT       = 0,
    parameter int ROUND       = 0,
    parameter int SATURATE    = 0,
    parameter int USER_WIDTH  = 1
) (
    input logic ap_clk,
    input logic ap_rst,
    pfb_block_decimator_mul_pipe_if.slave bus
);

    localparam int PW         = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int OUT_SIGNED = (DIN0_SIGNED != 0 || DIN1_SIGNED != 0) ? 1 : 0;

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
        $error("pfb_block_decimator_mul_pipe: NUM_STAGE=%0d outside %0d..%0d",
               NUM_STAGE, NUM_STAGE_MIN, NUM_STAGE_MAX);
    end
    if (SHIFT < SHIFT_MIN || SHIFT > shift_max(DIN0_WIDTH, DIN1_WIDTH)) begin : g_bad_shift
        $error("pfb_block_decimator_mul_pipe: SHIFT=%0d outside %0d..%0d",
               SHIFT, SHIFT_MIN, shift_max(DIN0_WIDTH, DIN1_WIDTH));
    end
    if (DOUT_WIDTH < 1 || DOUT_WIDTH > MAX_DOUT_WIDTH || USER_WIDTH < 1 ||
        DIN0_WIDTH < 1 || DIN1_WIDTH < 1) begin : g_bad_width
        $error("pfb_block_decimator_mul_pipe: illegal width parameter");
    end
    if ((DIN0_SIGNED != 0 && DIN0_SIGNED != 1) || (DIN1_SIGNED != 0 && DIN1_SIGNED != 1) ||
        (ROUND != 0 && ROUND != 1) || (SATURATE != 0 && SATURATE != 1)) begin : g_bad_flag
        $error("pfb_block_decimator_mul_pipe: SIGNED/ROUND/SATURATE must be 0 or 1");
    end

    logic                                   en;
    logic [NUM_STAGE-1:0]                   vld_q, vld_d;
    logic [NUM_STAGE:0]                     vld_cat;
    logic [NUM_STAGE-1:0][USER_WIDTH-1:0]   user_q, user_d;
    logic [NUM_STAGE:0][USER_WIDTH-1:0]     user_cat;
    logic [DOUT_WIDTH-1:0]                  dout_q, dout_d;
    logic                                   sat_q, sat_d;

    logic [DIN0_WIDTH-1:0]                  mul_a;
    logic [DIN1_WIDTH-1:0]                  mul_b;
    logic signed [DIN0_WIDTH:0]             a_ext;
    logic signed [DIN1_WIDTH:0]             b_ext;
    logic signed [PW-1:0]                   mul_p;
    logic signed [PW-1:0]                   scale_in;
    logic [DOUT_WIDTH-1:0]                  scale_dout;
    logic                                   scale_sat;

    // Index 0 of each chain is the live input; index NUM_STAGE is the output stage.
    assign vld_cat  = {vld_q, bus.in_valid};
    assign user_cat = {user_q, bus.in_user};
    assign en       = !vld_cat[NUM_STAGE] || bus.out_ready;

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_cat[NUM_STAGE];
    assign bus.out_user  = user_cat[NUM_STAGE];
    assign bus.dout      = dout_q;
    assign bus.out_sat   = sat_q;

    if (NUM_STAGE == 1) begin : g_comb_operands
        assign mul_a = bus.din0;
        assign mul_b = bus.din1;
    end else begin : g_reg_operands
        logic [DIN0_WIDTH-1:0] a_q, a_d;
        logic [DIN1_WIDTH-1:0] b_q, b_d;

        always_comb begin
            a_d = a_q;
            b_d = b_q;
            if (en) begin
                a_d = bus.din0;
                b_d = bus.din1;
            end
        end

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                a_q <= '0;
                b_q <= '0;
            end else begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end

        assign mul_a = a_q;
        assign mul_b = b_q;
    end

    always_comb begin
        a_ext = {(DIN0_SIGNED != 0) ? mul_a[DIN0_WIDTH-1] : 1'b0, mul_a};
        b_ext = {(DIN1_SIGNED != 0) ? mul_b[DIN1_WIDTH-1] : 1'b0, mul_b};
        mul_p = PW'(a_ext) * PW'(b_ext);
    end

    if (NUM_STAGE <= 2) begin : g_no_mid
        assign scale_in = mul_p;
    end else begin : g_mid
        logic signed [PW-1:0] prod_q [NUM_STAGE-2];
        logic signed [PW-1:0] prod_d [NUM_STAGE-2];

        always_comb begin
            prod_d = prod_q;
            if (en) begin
                prod_d[0] = mul_p;
                for (int i = 1; i < NUM_STAGE - 2; i++) begin
                    prod_d[i] = prod_q[i-1];
                end
            end
        end

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                for (int i = 0; i < NUM_STAGE - 2; i++) begin
                    prod_q[i] <= '0;
                end
            end else begin
                prod_q <= prod_d;
            end
        end

        assign scale_in = prod_q[NUM_STAGE-3];
    end

    pfb_mul_scale #(
        .PROD_WIDTH (PW),
        .DOUT_WIDTH (DOUT_WIDTH),
        .OUT_SIGNED (OUT_SIGNED),
        .SHIFT      (SHIFT),
        .ROUND      (ROUND),
        .SATURATE   (SATURATE)
    ) u_scale (
        .prod (scale_in),
        .dout (scale_dout),
        .sat  (scale_sat)
    );

    // The result register only loads real beats, so a bubble never disturbs the last result.
    always_comb begin
        vld_d  = vld_q;
        user_d = user_q;
        dout_d = dout_q;
        sat_d  = sat_q;
        if (en) begin
            vld_d  = vld_cat[NUM_STAGE-1:0];
            user_d = user_cat[NUM_STAGE-1:0];
            if (vld_cat[NUM_STAGE-1]) begin
                dout_d = scale_dout;
                sat_d  = scale_sat;
            end else begin
                user_d[NUM_STAGE-1] = user_q[NUM_STAGE-1];
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            vld_q  <= '0;
            user_q <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            user_q <= user_d;
            dout_q <= dout_d;
            sat_q  <= sat_d;
        end
    end

endmodule

// File: tb/tb_pfb_block_decimator_mul_pipe.sv
// Directed bench: seven multiplier configurations share one operand stream and are checked per step.
module tb_pfb_block_decimator_mul_pipe;

    localparam int NDUT = 7;
    // u0 unsigned/3 stages, u1 +saturate, u2 signed+saturate, u3 shift4 round, u4 shift4 floor,
    // u5 single stage, u6 six stages
    localparam int CFG_SGN [NDUT] = '{0, 0, 1, 1, 1, 0, 0};
    localparam int CFG_NS  [NDUT] = '{3, 3, 3, 3, 3, 1, 6};
    localparam int CFG_SAT [NDUT] = '{0, 1, 1, 0, 0, 0, 0};
    localparam int CFG_SH  [NDUT] = '{0, 0, 0, 4, 4, 0, 0};
    localparam int CFG_RND [NDUT] = '{0, 0, 0, 1, 0, 0, 0};

    logic        ap_clk;
    logic        ap_rst;
    logic        in_valid;
    logic        out_ready;
    logic [10:0] din0;
    logic [12:0] din1;
    logic [3:0]  in_user;

    int nvec;
    int nfail;

    pfb_block_decimator_mul_pipe_if #(.USER_WIDTH(4)) bus [NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign bus[g].in_valid  = in_valid;
        assign bus[g].din0      = din0;
        assign bus[g].din1      = din1;
        assign bus[g].in_user   = in_user;
        assign bus[g].out_ready = out_ready;

        pfb_block_decimator_mul_pipe #(
            .DIN0_WIDTH  (11),
            .DIN1_WIDTH  (13),
            .DOUT_WIDTH  (23),
            .DIN0_SIGNED (CFG_SGN[g]),
            .DIN1_SIGNED (CFG_SGN[g]),
            .NUM_STAGE   (CFG_NS[g]),
            .SHIFT       (CFG_SH[g]),
            .ROUND       (CFG_RND[g]),
            .SATURATE    (CFG_SAT[g]),
            .USER_WIDTH  (4)
        ) u_dut (
            .ap_clk (ap_clk),
            .ap_rst (ap_rst),
            .bus    (bus[g])
        );
    end

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nvec++;
        assert (observed === expected) else begin
            nfail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] a, input logic [12:0] b, input logic [3:0] u);
        @(negedge ap_clk);
        din0     = a;
        din1     = b;
        in_user  = u;
        in_valid = 1'b1;
    endtask

    // One beat, then wait until a three-stage pipe presents it.
    task automatic sendBeat(input logic [10:0] a, input logic [12:0] b, input logic [3:0] u);
        applyStimulus(a, b, u);
        @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (2) @(negedge ap_clk);
    endtask

    // Follows one just-driven beat through the 1-, 3- and 6-stage pipes cycle by cycle.
    task automatic runLatency(input string tag, input logic [22:0] expDout, input logic [3:0] expUser,
                              input bit checkSat);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge ap_clk);
            if (cyc == 1) in_valid = 1'b0;
            checkOutput({tag, "_u0_vld"}, 32'(bus[0].out_valid), 32'(cyc == 3));
            checkOutput({tag, "_u5_vld"}, 32'(bus[5].out_valid), 32'(cyc == 1));
            checkOutput({tag, "_u6_vld"}, 32'(bus[6].out_valid), 32'(cyc == 6));
            if (cyc == 1) checkOutput({tag, "_u5_dout"}, 32'(bus[5].dout), 32'(expDout));
            if (cyc == 6) checkOutput({tag, "_u6_dout"}, 32'(bus[6].dout), 32'(expDout));
            if (cyc == 3) begin
                checkOutput({tag, "_u0_dout"}, 32'(bus[0].dout), 32'(expDout));
                checkOutput({tag, "_u0_user"}, 32'(bus[0].out_user), 32'(expUser));
                checkOutput({tag, "_u0_sat"}, 32'(bus[0].out_sat), 32'(0));
                if (checkSat) begin
                    checkOutput({tag, "_u1_dout"}, 32'(bus[1].dout), 32'(8388607));
                    checkOutput({tag, "_u1_sat"}, 32'(bus[1].out_sat), 32'(1));
                    checkOutput({tag, "_u2_dout"}, 32'(bus[2].dout), 32'(1));
                    checkOutput({tag, "_u2_sat"}, 32'(bus[2].out_sat), 32'(0));
                end
            end
        end
    endtask

    function automatic logic [31:0] expProd(input int k);
        return 32'((100 + 37 * k) * (11 + 3 * k));
    endfunction

    initial begin
        logic [2:0] mv;
        int         tx;
        int         rx;

        nvec      = 0;
        nfail     = 0;
        ap_rst    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        in_user   = '0;

        // Reset: everything clear and in_ready high even with out_ready low.
        #1 ap_rst = 1'b1;
        repeat (2) @(negedge ap_clk);
        checkOutput("rst_out_valid", 32'(bus[0].out_valid), 32'(0));
        checkOutput("rst_dout", 32'(bus[0].dout), 32'(0));
        checkOutput("rst_out_sat", 32'(bus[0].out_sat), 32'(0));
        checkOutput("rst_out_user", 32'(bus[0].out_user), 32'(0));
        checkOutput("rst_in_ready", 32'(bus[0].in_ready), 32'(1));
        checkOutput("rst_u6_valid", 32'(bus[6].out_valid), 32'(0));
        out_ready = 1'b1;
        ap_rst    = 1'b0;

        // Unsigned maximum operands: truncation, clamp, latency for 1/3/6 stages.
        applyStimulus(11'd2047, 13'd8191, 4'd5);
        runLatency("max", 23'd8378369, 4'd5, 1'b1);

        // Signed clamp and plain signed results.
        sendBeat(11'h400, 13'h1000, 4'd1);
        checkOutput("sgn_clamp_vld", 32'(bus[2].out_valid), 32'(1));
        checkOutput("sgn_clamp_dout", 32'(bus[2].dout), 32'(4194303));
        checkOutput("sgn_clamp_sat", 32'(bus[2].out_sat), 32'(1));
        checkOutput("uns_1024x4096", 32'(bus[0].dout), 32'(4194304));
        sendBeat(11'h7FF, 13'd5, 4'd2);
        checkOutput("sgn_m1x5_dout", 32'(bus[2].dout), 32'(23'h7FFFFB));
        checkOutput("sgn_m1x5_sat", 32'(bus[2].out_sat), 32'(0));
        checkOutput("uns_2047x5", 32'(bus[0].dout), 32'(10235));

        // Shift by 4 with and without rounding.
        sendBeat(11'd3, 13'd14, 4'd3);
        checkOutput("sh_42_round", 32'(bus[3].dout), 32'(3));
        checkOutput("sh_42_floor", 32'(bus[4].dout), 32'(2));
        sendBeat(11'h7FD, 13'd14, 4'd4);
        checkOutput("sh_m42_round", 32'(bus[3].dout), 32'(23'h7FFFFD));
        checkOutput("sh_m42_floor", 32'(bus[4].dout), 32'(23'h7FFFFD));
        sendBeat(11'h7FF, 13'd8, 4'd5);
        checkOutput("sh_m8_round", 32'(bus[3].dout), 32'(0));
        checkOutput("sh_m8_floor", 32'(bus[4].dout), 32'(23'h7FFFFF));
        checkOutput("sh_m8_user", 32'(bus[3].out_user), 32'(5));

        // Backpressure on the three-stage unsigned pipe against a valid-chain model.
        mv = '0;
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 200 && rx < 8; cyc++) begin
            @(negedge ap_clk);
            out_ready = ($urandom_range(0, 9) >= 4);
            in_valid  = (tx < 8);
            din0      = 11'(100 + 37 * tx);
            din1      = 13'(11 + 3 * tx);
            in_user   = 4'(tx);
            #1;
            checkOutput("bp_out_valid", 32'(bus[0].out_valid), 32'(mv[2]));
            checkOutput("bp_in_ready", 32'(bus[0].in_ready), 32'(!mv[2] || out_ready));
            if (mv[2]) begin
                checkOutput("bp_dout", 32'(bus[0].dout), expProd(rx));
                checkOutput("bp_user", 32'(bus[0].out_user), 32'(rx));
                if (out_ready) rx++;
            end
            if (!mv[2] || out_ready) begin
                if (in_valid) tx++;
                mv = {mv[1:0], in_valid};
            end
        end
        checkOutput("bp_received", 32'(rx), 32'(8));

        @(negedge ap_clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge ap_clk);

        // Asynchronous reset with two beats in flight.
        applyStimulus(11'd7, 13'd9, 4'd1);
        applyStimulus(11'd8, 13'd9, 4'd2);
        @(negedge ap_clk);
        in_valid = 1'b0;
        checkOutput("mid_u5_vld", 32'(bus[5].out_valid), 32'(1));
        checkOutput("mid_u5_dout", 32'(bus[5].dout), 32'(72));
        @(negedge ap_clk);
        checkOutput("mid_u0_vld", 32'(bus[0].out_valid), 32'(1));
        checkOutput("mid_u0_dout", 32'(bus[0].dout), 32'(63));
        checkOutput("mid_u6_vld", 32'(bus[6].out_valid), 32'(0));
        #2 ap_rst = 1'b1;
        #1;
        checkOutput("arst_u0_vld", 32'(bus[0].out_valid), 32'(0));
        checkOutput("arst_u0_dout", 32'(bus[0].dout), 32'(0));
        checkOutput("arst_u0_user", 32'(bus[0].out_user), 32'(0));
        checkOutput("arst_u5_vld", 32'(bus[5].out_valid), 32'(0));
        checkOutput("arst_u6_vld", 32'(bus[6].out_valid), 32'(0));
        checkOutput("arst_in_ready", 32'(bus[0].in_ready), 32'(1));
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;

        applyStimulus(11'd5, 13'd6, 4'd3);
        runLatency("post_rst", 23'd30, 4'd3, 1'b0);

        $display("[TB] directed sequence complete");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
